// File: rtl/lfsr_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_step_ctrl
// Purpose  : Turns a bouncy push-switch and mode selector into single-cycle
//            LFSR step pulses (manual, auto-rate, burst) with a step counter.
// Revision : 1.0
// ============================================================================
module lfsr_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PERIOD_BASE     = 16,
    parameter int TIMER_W         = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_step,
    input  logic [1:0] mode,
    input  logic [1:0] rate_sel,
    input  logic [3:0] burst_len,
    output logic       step,
    output logic       busy,
    output logic [7:0] step_count
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_AUTO   = 2'b01;
    localparam logic [1:0] MODE_BURST  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_AUTO  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    logic [1:0]         sync_q, sync_d;
    logic               db_level_q, db_level_d;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic               db_prev_q, db_prev_d;
    logic               press_q, press_d;
    logic [1:0]         mode_reg_q, mode_reg_d;
    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [4:0]         remaining_q, remaining_d;
    logic               step_q, step_d;
    logic               busy_q, busy_d;
    logic [7:0]         step_count_q, step_count_d;

    logic               mode_change;
    logic [TIMER_W-1:0] period_m1;
    logic               expire;

    // Input conditioning: sync stage 1 is bit 0, the debouncer watches bit 1.
    always_comb begin
        sync_d     = {sync_q[0], btn_step};
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        if (sync_q[1] != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = ~db_level_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
        db_prev_d = db_level_q;
        press_d   = db_level_q & ~db_prev_q;
    end

    assign mode_reg_d  = mode;
    assign mode_change = (mode != mode_reg_q);

    // Comparing with >= lets a shortened period fire at once instead of waiting a wrap.
    assign period_m1 = (TIMER_W'(PERIOD_BASE) << rate_sel) - TIMER_W'(1);
    assign expire    = (timer_q >= period_m1);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        remaining_d = remaining_q;
        step_d      = 1'b0;

        if (mode_change) begin
            state_d     = ST_IDLE;
            timer_d     = '0;
            remaining_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    case (mode_reg_q)
                        MODE_MANUAL: step_d = press_q;
                        MODE_AUTO: begin
                            state_d = ST_AUTO;
                            timer_d = '0;
                        end
                        MODE_BURST: begin
                            if (press_q) begin
                                remaining_d = (burst_len == 4'd0) ? 5'd16 : {1'b0, burst_len};
                                timer_d     = '0;
                                state_d     = ST_BURST;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_AUTO, ST_BURST: begin
                    if (expire) begin
                        step_d  = 1'b1;
                        timer_d = '0;
                        if (state_q == ST_BURST) begin
                            remaining_d = remaining_q - 5'd1;
                            if (remaining_q == 5'd1) begin
                                state_d = ST_IDLE;
                            end
                        end
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign busy_d       = (state_d == ST_BURST);
    assign step_count_d = step_count_q + {7'd0, step_q};

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q       <= '0;
            db_level_q   <= 1'b0;
            db_cnt_q     <= '0;
            db_prev_q    <= 1'b0;
            press_q      <= 1'b0;
            mode_reg_q   <= 2'b00;
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            remaining_q  <= '0;
            step_q       <= 1'b0;
            busy_q       <= 1'b0;
            step_count_q <= '0;
        end else begin
            sync_q       <= sync_d;
            db_level_q   <= db_level_d;
            db_cnt_q     <= db_cnt_d;
            db_prev_q    <= db_prev_d;
            press_q      <= press_d;
            mode_reg_q   <= mode_reg_d;
            state_q      <= state_d;
            timer_q      <= timer_d;
            remaining_q  <= remaining_d;
            step_q       <= step_d;
            busy_q       <= busy_d;
            step_count_q <= step_count_d;
        end
    end

    assign step       = step_q;
    assign busy       = busy_q;
    assign step_count = step_count_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_step_ctrl.sv
`default_nettype none
// Bench for lfsr_step_ctrl: vector table, directed corner sequences and a
// randomized run, all cross-checked every cycle against a reference model.
module tb_lfsr_step_ctrl;

    localparam int DB_N  = 4;
    localparam int PBASE = 16;
    localparam int A_IDLE  = 0;
    localparam int A_AUTO  = 1;
    localparam int A_BURST = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_step = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [1:0] rate_sel = 2'b00;
    logic [3:0] burst_len = 4'd0;
    logic       step;
    logic       busy;
    logic [7:0] step_count;

    lfsr_step_ctrl #(
        .DEBOUNCE_CYCLES(DB_N),
        .PERIOD_BASE    (PBASE),
        .TIMER_W        (24)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_step  (btn_step),
        .mode      (mode),
        .rate_sel  (rate_sel),
        .burst_len (burst_len),
        .step      (step),
        .busy      (busy),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulses[$];
    bit pulse_busy[$];

    // Reference model state, kept in terms of observable behaviour
    bit m_sync[$] = '{1'b0, 1'b0};
    bit m_win[$];
    bit m_level = 1'b0;
    int m_press_at[$];
    bit [1:0] m_mode_prev = 2'b00;
    int m_act = A_IDLE;
    int m_elapsed = 0;
    int m_left = 0;
    bit e_step = 1'b0;
    bit e_busy = 1'b0;
    int e_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_step();
        bit seen;
        bit press_now;
        bit all_diff;
        bit changed;
        int period;
        if (!rst) begin
            m_sync = '{1'b0, 1'b0};
            m_win.delete();
            m_press_at.delete();
            m_level = 1'b0;
            m_mode_prev = 2'b00;
            m_act = A_IDLE;
            m_elapsed = 0;
            m_left = 0;
            e_step = 1'b0;
            e_busy = 1'b0;
            e_count = 0;
            return;
        end
        e_count = (e_count + int'(e_step)) % 256;

        seen = m_sync.pop_front();
        m_sync.push_back(btn_step);
        press_now = 1'b0;
        if (m_press_at.size() > 0 && m_press_at[0] == cyc) begin
            press_now = 1'b1;
            void'(m_press_at.pop_front());
        end
        // Level flips once the last DB_N samples since the previous flip all disagree
        m_win.push_back(seen);
        if (m_win.size() > DB_N) void'(m_win.pop_front());
        all_diff = (m_win.size() == DB_N);
        foreach (m_win[k]) if (m_win[k] == m_level) all_diff = 1'b0;
        if (all_diff) begin
            m_level = ~m_level;
            m_win.delete();
            if (m_level) m_press_at.push_back(cyc + 2);
        end

        changed = (mode != m_mode_prev);
        m_mode_prev = mode;
        e_step = 1'b0;
        if (changed) begin
            m_act = A_IDLE;
            m_elapsed = 0;
            m_left = 0;
        end else if (m_act == A_IDLE) begin
            if (mode == 2'b00) begin
                e_step = press_now;
            end else if (mode == 2'b01) begin
                m_act = A_AUTO;
                m_elapsed = 0;
            end else if (mode == 2'b10 && press_now) begin
                m_left = (burst_len == 0) ? 16 : int'(burst_len);
                m_elapsed = 0;
                m_act = A_BURST;
            end
        end else begin
            period = PBASE << rate_sel;
            if (m_elapsed >= period - 1) begin
                e_step = 1'b1;
                m_elapsed = 0;
                if (m_act == A_BURST) begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_act = A_IDLE;
                end
            end else begin
                m_elapsed = m_elapsed + 1;
            end
        end
        e_busy = (m_act == A_BURST);
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        check("step", {31'd0, step}, {31'd0, e_step});
        check("busy", {31'd0, busy}, {31'd0, e_busy});
        check("step_count", {24'd0, step_count}, e_count);
        if (step === 1'b1) begin
            pulses.push_back(cyc);
            pulse_busy.push_back(busy);
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        btn_step = 1'b0;
        repeat (n) tick();
        rst = 1'b1;
        pulses.delete();
        pulse_busy.delete();
    endtask

    task automatic wait_pulses(input int n, input int budget, input string name);
        int k = 0;
        while (pulses.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(name, {31'd0, pulses.size() >= n}, 32'd1);
    endtask

    task automatic press(input int hold);
        btn_step = 1'b1;
        run(hold);
        btn_step = 1'b0;
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [1:0] rate;
        logic [3:0] blen;
        bit         press;
        int         cycles;
        int         exp_pulses;
        bit         exp_busy;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int c0;
        int n0;
        int hold;

        vecs[0]  = '{2'b01, 2'd0, 4'd0, 1'b0, 100, 6, 1'b0};
        vecs[1]  = '{2'b01, 2'd2, 4'd0, 1'b0, 150, 2, 1'b0};
        vecs[2]  = '{2'b01, 2'd3, 4'd0, 1'b0, 130, 1, 1'b0};
        vecs[3]  = '{2'b00, 2'd0, 4'd0, 1'b0, 50,  0, 1'b0};
        vecs[4]  = '{2'b00, 2'd0, 4'd0, 1'b1, 50,  1, 1'b0};
        vecs[5]  = '{2'b11, 2'd0, 4'd0, 1'b1, 50,  0, 1'b0};
        vecs[6]  = '{2'b10, 2'd0, 4'd3, 1'b1, 100, 3, 1'b0};
        vecs[7]  = '{2'b10, 2'd0, 4'd3, 1'b1, 50,  2, 1'b1};
        vecs[8]  = '{2'b10, 2'd1, 4'd1, 1'b1, 60,  1, 1'b0};
        vecs[9]  = '{2'b10, 2'd0, 4'd2, 1'b0, 60,  0, 1'b0};
        vecs[10] = '{2'b01, 2'd0, 4'd0, 1'b1, 40,  2, 1'b0};

        // Reset held with a toggling button
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            btn_step = i[0];
            tick();
            check("reset_step", {31'd0, step}, 32'd0);
            check("reset_busy", {31'd0, busy}, 32'd0);
            check("reset_count", {24'd0, step_count}, 32'd0);
        end
        btn_step = 1'b0;
        rst = 1'b1;
        tick();
        check("post_reset_step", {31'd0, step}, 32'd0);
        check("post_reset_count", {24'd0, step_count}, 32'd0);

        // Manual debounce: 10 cycles of bounce, then held high
        pulses.delete();
        c0 = 0;
        for (int i = 0; i < 10; i++) begin
            btn_step = i[0];
            c0 = cyc;
            tick();
        end
        run(20);
        check("manual_one_pulse", pulses.size(), 1);
        check("manual_latency_8pm1", {31'd0, pulses.size() == 1 && (pulses[0] - c0) >= 7 && (pulses[0] - c0) <= 9}, 32'd1);
        check("manual_count1", {24'd0, step_count}, 32'd1);
        btn_step = 1'b0;
        run(12);
        press(12);
        check("manual_count2", {24'd0, step_count}, 32'd2);

        // Vector table
        foreach (vecs[v]) begin
            mode = vecs[v].mode;
            rate_sel = vecs[v].rate;
            burst_len = vecs[v].blen;
            do_reset(2);
            for (int i = 0; i < vecs[v].cycles; i++) begin
                btn_step = vecs[v].press && (i < 12);
                tick();
            end
            btn_step = 1'b0;
            check($sformatf("vec%0d_pulses", v), pulses.size(), vecs[v].exp_pulses);
            check($sformatf("vec%0d_busy", v), {31'd0, busy}, {31'd0, vecs[v].exp_busy});
        end

        // Auto rate 32, then switch to 16
        mode = 2'b00;
        rate_sel = 2'd1;
        do_reset(2);
        mode = 2'b01;
        c0 = cyc;
        run(200);
        check("auto_pulse_count", pulses.size(), 6);
        if (pulses.size() > 0) check("auto_first_pulse", pulses[0] - c0, 34);
        for (int i = 1; i < pulses.size(); i++) check("auto_spacing32", pulses[i] - pulses[i-1], 32);
        n0 = pulses.size();
        rate_sel = 2'd0;
        run(60);
        check("auto_fast_count", pulses.size() - n0, 4);
        for (int i = (n0 > 0 ? n0 : 1); i < pulses.size(); i++) check("auto_spacing16", pulses[i] - pulses[i-1], 16);

        // Burst with length 0 (=16); a second press mid-burst is ignored
        mode = 2'b10;
        rate_sel = 2'd0;
        burst_len = 4'd0;
        do_reset(2);
        run(5);
        press(12);
        check("burst_busy_high", {31'd0, busy}, 32'd1);
        run(90);
        press(12);
        run(250);
        check("burst16_pulses", pulses.size(), 16);
        for (int i = 1; i < pulses.size(); i++) check("burst_spacing", pulses[i] - pulses[i-1], 16);
        if (pulses.size() == 16) begin
            check("burst_busy_at15", {31'd0, pulse_busy[14]}, 32'd1);
            check("burst_busy_at16", {31'd0, pulse_busy[15]}, 32'd0);
        end
        check("burst16_count", {24'd0, step_count}, 32'd16);

        // Mode change aborts a 5-step burst after 3 steps
        burst_len = 4'd5;
        do_reset(2);
        press(12);
        wait_pulses(3, 200, "abort_reach3");
        mode = 2'b11;
        tick();
        check("abort_busy_low", {31'd0, busy}, 32'd0);
        run(100);
        check("abort_pulses", pulses.size(), 3);
        check("abort_count", {24'd0, step_count}, 32'd3);
        mode = 2'b10;
        run(100);
        check("abort_no_restart", pulses.size(), 3);

        // Counter wrap, then reset mid-period
        mode = 2'b01;
        rate_sel = 2'd0;
        do_reset(2);
        wait_pulses(257, 5000, "wrap_reach257");
        tick();
        check("wrap_count", {24'd0, step_count}, 32'd1);
        run(5);
        rst = 1'b0;
        tick();
        check("midreset_count", {24'd0, step_count}, 32'd0);
        check("midreset_step", {31'd0, step}, 32'd0);
        rst = 1'b1;
        tick();
        check("after_reset_step1", {31'd0, step}, 32'd0);
        tick();
        check("after_reset_step2", {31'd0, step}, 32'd0);

        // Randomized run against the model
        mode = 2'b10;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                btn_step = ~btn_step;
                hold = $urandom_range(1, 12);
            end else begin
                hold--;
            end
            if ($urandom_range(0, 149) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) rate_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) burst_len = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 799) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lfsr_step_ctrl.md
# lfsr_step_ctrl

Sequencing controller for the 8-bit random-number LFSR on the board top level. It turns a raw, bouncy push-switch and a mode selector into clean single-cycle `step` pulses for the LFSR's advance input. It supports manual single-step, free-running auto-step at a selectable rate, and fixed-length bursts. It also keeps a wrap-around count of issued steps for display on the hex digits.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required before the debounced button level changes. Use 4 in simulation and 500000 on the board.
- `PERIOD_BASE`, default 16: auto/burst step period in clock cycles at `rate_sel`=0. Must be ≥2.
- `TIMER_W`, default 24: width of the period timer. It must hold `PERIOD_BASE<<3`.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: reset, synchronous and active-low.
- `btn_step`, in, 1: raw push-switch, asynchronous to `clk`, bouncy.
- `mode`, in, 2: 00 manual, 01 auto, 10 burst, 11 hold.
- `rate_sel`, in, 2: step period is `PERIOD_BASE << rate_sel` cycles.
- `burst_len`, in, 4: number of steps per burst; 0 means 16.
- `step`, out, 1: one-cycle advance pulse to the LFSR.
- `busy`, out, 1: high while a burst is in progress.
- `step_count`, out, 8: number of `step` pulses issued, modulo 256.

## Operation

- **Input conditioning**
  - `btn_step` passes through a 2-flop synchronizer, then the debouncer.
  - The debounced level changes only after the synchronized value has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any mismatch-free cycle clears the debounce counter.
  - A press event is a one-cycle pulse on a 0→1 transition of the debounced level.
- **Mode tracking**
  - `mode` is registered every cycle.
  - When `mode` differs from the registered value, a mode change occurs. On that cycle:
    - the FSM goes to IDLE;
    - the timer clears;
    - the burst remaining count clears;
    - `step`=0.
- **FSM states:** IDLE, AUTO, BURST.
  - **IDLE**
    - mode 00: a press event gives `step`=1 on the following cycle.
    - mode 01: go to AUTO with the timer at 0.
    - mode 10: a press event loads remaining=`burst_len` (0→16), clears the timer, and goes to BURST.
    - mode 11: nothing happens; presses are discarded.
  - **AUTO**
    - The timer increments each cycle.
    - When timer = period−1: `step`=1 and the timer returns to 0.
    - Exit only on a mode change.
  - **BURST**
    - `busy`=1. The timer runs as in AUTO.
    - On each expiry: `step`=1 and remaining decrements.
    - On the expiry where remaining=1: step, then go to IDLE; `busy` drops in the same cycle as the final step is registered.
    - Press events in BURST are ignored and not queued.
- **Period**
  - `rate_sel` is sampled continuously.
  - A change mid-period takes effect at the next comparison. If the timer is already ≥ the new period−1, it fires on the next cycle and then wraps.
- **Counter**
  - `step_count` increments by 1 on every cycle in which `step`=1.
  - It wraps from 255 to 0 with no flag.

## Timing

- Reset: on a `clk` edge with `rst`=0, the following take their reset values:
  - `step`=0, `busy`=0, `step_count`=0;
  - FSM in IDLE, timer 0, remaining 0;
  - synchronizer and debounced level 0, debounce counter 0.
  - Registered mode = 00.
- Reset mid-burst or mid-period aborts immediately. No `step` is issued on the reset cycle or the cycle after.
- Press latency: the raw edge stable at the synchronizer input yields `step` after 2 (sync) + `DEBOUNCE_CYCLES` + 1 (edge) + 1 (output register) cycles. Jitter is ±1 cycle for asynchronous sampling.
- Auto mode: the first `step` occurs exactly `period` cycles after the cycle the FSM enters AUTO. Subsequent steps are spaced exactly `period` cycles.
- Burst: N steps spaced `period` apart. The first step occurs `period` cycles after the press event. `busy` rises the cycle after the press event.
- `step` is never high for two consecutive cycles, because period ≥2.
- A mode change coincident with a timer expiry: the mode change wins and no step is issued.
- A press event coincident with a mode change: the press is discarded.

## Test plan

- **Reset:** hold `rst`=0 for 3 cycles with `btn_step` toggling → `step`=0, `busy`=0, `step_count`=0 throughout and on the first cycle after release.
- **Manual debounce:** mode 00, `btn_step` bounces 0/1 every cycle for 10 cycles, then is held at 1 → exactly one `step` pulse, 2+4+2 cycles after the last bounce; `step_count`=1. Release and press again → `step_count`=2.
- **Auto rate:** mode 01, `rate_sel`=1 (period 32), run 200 cycles → 6 pulses spaced exactly 32 cycles apart. Switch `rate_sel` to 0 → spacing 16 from the next pulse.
- **Burst with zero length:** mode 10, `burst_len`=0, press → `busy` high, 16 pulses spaced 16 cycles apart, `busy` low after the 16th. A second press mid-burst adds no pulses; `step_count`=16.
- **Mode change abort:** mid-burst (after 3 steps of 5), set mode 11 → no further steps, `busy`=0 next cycle, `step_count`=3. Return to mode 10 → no step until a new press.
- **Wrap:** auto at `rate_sel`=0 for 257 periods → `step_count` reads 1 after the 257th pulse. Assert `rst`=0 mid-period → `step_count`=0, no pulse for 2 cycles.
